lh_msg_framer: RTL and testbench
================================

// Module: lh_msg_framer
// PURPOSE
//  Transmit side of the light-hash byte protocol. Buffers one host message, checks its characters,
//  then frames it toward the light-hash core: head 0xFF, body bytes, tail 0x00.
//  Captures the returned 64-bit digest, or an error, and presents it on a valid/ready result port.
//  Sits between the host byte stream and the hash core's message_byte/message_valid/digest inputs.
// PARAMETERS
//  MAX_LEN         32  max body bytes per message; power of 2, <=32 (matches the core's iteration window)
//  DIGEST_TIMEOUT  16  cycles to wait for digest_ready after the tail byte is driven
// PORTS
//  clk                  in   1   clock
//  rst                  in   1   synchronous reset, active-high
//  in_byte              in   8   host message byte
//  in_valid             in   1   in_byte valid
//  in_last              in   1   in_byte is the final byte of the message
//  in_ready             out  1   framer accepts the host byte this cycle
//  message_byte         out  8   byte to the hash core
//  message_valid        out  1   start-of-message strobe to the core
//  digest               in   64  core digest
//  digest_ready         in   1   core digest valid
//  err_invalid_message_byte in 1  core rejected the current byte
//  result_digest        out  64  captured digest; 0 on any error
//  result_err           out  2   0 OK, 1 BAD_CHAR, 2 OVERFLOW, 3 TIMEOUT
//  result_valid         out  1   result available; held until result_ready
//  result_ready         in   1   consumer takes the result
// BEHAVIOUR
//  Reset values:
//   - message_byte=0xFF, message_valid=0, in_ready=1, result_valid=0, result_digest=0, result_err=0.
//   - FSM=LOAD, length/pointer=0, poison flags cleared.
//  Reset asserted in any state aborts the message; the same reset values appear the next cycle.
//  Character rules:
//   - Valid body bytes are 0x20..0x7E and 0xA1..0xFE.
//   - 0x00 and 0xFF are reserved for tail and head, so they are BAD_CHAR.
//  FSM states:
//   - LOAD: in_ready=1. Every in_valid byte is handshaked.
//     - Valid bytes are stored while len<MAX_LEN; len increments.
//     - An invalid byte sets the bad flag. A byte arriving with len==MAX_LEN sets the ovf flag.
//     - On handshake with in_last:
//       - if a flag is set, go to RESULT with err BAD_CHAR (priority) or OVERFLOW;
//       - otherwise go to HEAD.
//   - HEAD (1 cycle): message_byte=0xFF, message_valid=1, in_ready=0. Next state is BODY, rd_ptr=0.
//   - BODY: one stored byte per cycle on message_byte, message_valid=0. rd_ptr increments.
//     - After byte len-1, go to TAIL.
//     - If err_invalid_message_byte is seen in this state, go to RESULT with BAD_CHAR.
//   - TAIL/WAIT: message_byte=0x00 is held and a timer counts from 0.
//     - digest_ready=1: capture digest, err OK, go to RESULT.
//     - timer==DIGEST_TIMEOUT-1 with no digest_ready: err TIMEOUT, digest 0, go to RESULT.
//     - If digest_ready arrives in the same cycle as the timeout, digest_ready wins.
//   - RESULT: result_valid=1, message_byte=0xFF, in_ready=0.
//     - On result_valid&&result_ready: clear len/flags and go to LOAD; in_ready=1 the next cycle.
//  Latency: in_last handshake to head = 1 cycle. Head to tail = 1+len cycles.
//  Body order is strictly FIFO, with no gaps. Minimum message length is 1 byte (in_last always carries a byte).
//  Length counter width is clog2(MAX_LEN)+1 and it never wraps; overflow is flagged, never stored.
//  Outputs are registered, so no combinational path from digest_ready to result_valid.
// STRUCTURE
//  Package lh_pkg:
//   - HEAD_BYTE=8'hFF, TAIL_BYTE=8'h00, character range constants, function is_valid_char();
//   - typedef enum lh_err_e {LH_OK, LH_BAD_CHAR, LH_OVERFLOW, LH_TIMEOUT};
//   - typedef enum lh_fr_state_e {LOAD, HEAD, BODY, WAIT_DIG, RESULT}.
//  Sub-module lh_msg_buffer: MAX_LEN x 8 register array with write and read pointers.
//   - Synchronous write; combinational read at rd_ptr. Pointers clear on rst or on clear.
//  Top level holds the FSM, flags, timer and result registers.
// TESTING
//  1 "abc" (61,62,63 with last on 63); core model returns 64'h0123456789ABCDEF 2 cycles after tail
//    -> message_byte sequence FF(valid=1),61,62,63,00; result_digest=64'h0123456789ABCDEF, err=0.
//  2 "a",7F,"b" (last on "b") -> message_valid never asserted; result_err=1, result_digest=0.
//  3 33 bytes of 0x41 -> no head is sent; result_err=2.
//  4 "x" with core never raising digest_ready -> after 16 cycles of 00, result_err=3, result_digest=0.
//  5 result_ready low for 10 cycles -> result_valid and the result stay stable, in_ready=0;
//    after the handshake a new "z" is accepted.
//  6 rst pulsed during BODY of a 20-byte message -> next cycle message_byte=FF, message_valid=0,
//    in_ready=1; the following message hashes correctly.

Source files
------------

// File: rtl/lh_pkg.sv
// rtl/lh_pkg.sv - shared constants, types and character check for the light-hash framer
package lh_pkg;

    localparam int          BYTE_W      = 8;
    localparam logic [7:0]  HEAD_BYTE   = 8'hFF;
    localparam logic [7:0]  TAIL_BYTE   = 8'h00;
    localparam logic [7:0]  CHAR_LO_MIN = 8'h20;
    localparam logic [7:0]  CHAR_LO_MAX = 8'h7E;
    localparam logic [7:0]  CHAR_HI_MIN = 8'hA1;
    localparam logic [7:0]  CHAR_HI_MAX = 8'hFE;

    typedef enum logic [1:0] {
        LH_OK       = 2'd0,
        LH_BAD_CHAR = 2'd1,
        LH_OVERFLOW = 2'd2,
        LH_TIMEOUT  = 2'd3
    } lh_err_e;

    typedef enum logic [2:0] {
        LOAD,
        HEAD,
        BODY,
        WAIT_DIG,
        RESULT
    } lh_fr_state_e;

    // 0x00 and 0xFF fall outside both ranges, so the framing bytes can never appear in a body.
    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= CHAR_LO_MIN) && (b <= CHAR_LO_MAX)) ||
               ((b >= CHAR_HI_MIN) && (b <= CHAR_HI_MAX));
    endfunction

endpackage

// File: rtl/lh_msg_buffer.sv
// rtl/lh_msg_buffer.sv - message body store with write and read pointers
// Purpose: holds up to MAX_LEN body bytes; synchronous write, combinational read at the read pointer.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears both pointers)
//   i_clear      clears both pointers for the next message
//   i_wr_en      store i_wr_data at the write pointer and advance it
//   i_rd_en      advance the read pointer
//   o_rd_ptr     current read pointer
//   o_rd_data    byte at the read pointer
module lh_msg_buffer
    import lh_pkg::*;
#(
    parameter int MAX_LEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_wr_en,
    input  logic [BYTE_W-1:0]         i_wr_data,
    input  logic                      i_rd_en,
    output logic [$clog2(MAX_LEN):0]  o_rd_ptr,
    output logic [BYTE_W-1:0]         o_rd_data
);

    localparam int AW = $clog2(MAX_LEN);

    logic [BYTE_W-1:0] r_mem [MAX_LEN];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    // The writer never advances past MAX_LEN, so the low bits always address a real entry.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_rd_ptr  = r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/lh_msg_framer.sv
// rtl/lh_msg_framer.sv - transmit framer between the host byte stream and the light-hash core
// Purpose: buffers one host message, checks its characters, frames it as FF, body, 00 toward the
// core, then presents the captured digest or an error on a valid/ready result port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_byte/in_valid/in_last   host byte stream; in_ready accepts it (only while loading)
//   message_byte/message_valid byte and start-of-message strobe to the core
//   digest/digest_ready        digest returned by the core
//   err_invalid_message_byte   core rejected the byte currently being sent
//   result_digest/result_err   captured result (digest forced to 0 on any error)
//   result_valid/result_ready  result handshake; result held until taken
module lh_msg_framer
    import lh_pkg::*;
#(
    parameter int MAX_LEN        = 32,
    parameter int DIGEST_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  message_byte,
    output logic        message_valid,
    input  logic [63:0] digest,
    input  logic        digest_ready,
    input  logic        err_invalid_message_byte,
    output logic [63:0] result_digest,
    output logic [1:0]  result_err,
    output logic        result_valid,
    input  logic        result_ready
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int TW = $clog2(DIGEST_TIMEOUT + 1);

    lh_fr_state_e  r_state;
    lh_fr_state_e  w_state_nxt;
    logic [LW-1:0] r_len;
    logic          r_bad;
    logic          r_ovf;
    logic [TW-1:0] r_timer;
    logic [63:0]   r_result_digest;
    lh_err_e       r_result_err;

    logic          w_hs;
    logic          w_char_ok;
    logic          w_room;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_clear;
    logic          w_bad_nxt;
    logic          w_ovf_nxt;
    logic          w_cap;
    lh_err_e       w_cap_err;
    logic [63:0]   w_cap_digest;
    logic [LW-1:0] w_rd_ptr;
    logic [7:0]    w_rd_data;

    assign w_hs      = in_valid && (r_state == LOAD);
    assign w_char_ok = is_valid_char(in_byte);
    assign w_room    = r_len < LW'(MAX_LEN);
    assign w_wr_en   = w_hs && w_char_ok && w_room;
    // Flags include the byte being handshaked so the in_last byte itself can poison the message.
    assign w_bad_nxt = r_bad || (w_hs && !w_char_ok);
    assign w_ovf_nxt = r_ovf || (w_hs && !w_room);
    assign w_rd_en   = (r_state == BODY);
    assign w_clear   = (r_state == RESULT) && result_ready;

    lh_msg_buffer #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_wr_en   (w_wr_en),
        .i_wr_data (in_byte),
        .i_rd_en   (w_rd_en),
        .o_rd_ptr  (w_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Outputs decode only registered state, so nothing from digest_ready reaches them combinationally.
    always_comb begin
        w_state_nxt   = r_state;
        w_cap         = 1'b0;
        w_cap_err     = LH_OK;
        w_cap_digest  = '0;
        message_byte  = HEAD_BYTE;
        message_valid = 1'b0;
        in_ready      = 1'b0;
        result_valid  = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_hs && in_last) begin
                    if (w_bad_nxt) begin
                        w_state_nxt = RESULT;
                        w_cap       = 1'b1;
                        w_cap_err   = LH_BAD_CHAR;
                    end else if (w_ovf_nxt) begin
                        w_state_nxt = RESULT;
                        w_cap       = 1'b1;
                        w_cap_err   = LH_OVERFLOW;
                    end else begin
                        w_state_nxt = HEAD;
                    end
                end
            end
            HEAD: begin
                message_valid = 1'b1;
                w_state_nxt   = BODY;
            end
            BODY: begin
                message_byte = w_rd_data;
                if (err_invalid_message_byte) begin
                    w_state_nxt = RESULT;
                    w_cap       = 1'b1;
                    w_cap_err   = LH_BAD_CHAR;
                end else if (w_rd_ptr == r_len - LW'(1)) begin
                    w_state_nxt = WAIT_DIG;
                end
            end
            WAIT_DIG: begin
                message_byte = TAIL_BYTE;
                // digest_ready is tested first so it wins over a simultaneous timeout.
                if (digest_ready) begin
                    w_state_nxt  = RESULT;
                    w_cap        = 1'b1;
                    w_cap_err    = LH_OK;
                    w_cap_digest = digest;
                end else if (r_timer == TW'(DIGEST_TIMEOUT - 1)) begin
                    w_state_nxt = RESULT;
                    w_cap       = 1'b1;
                    w_cap_err   = LH_TIMEOUT;
                end
            end
            RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= LOAD;
            r_len           <= '0;
            r_bad           <= 1'b0;
            r_ovf           <= 1'b0;
            r_timer         <= '0;
            r_result_digest <= '0;
            r_result_err    <= LH_OK;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_len <= '0;
                r_bad <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_len <= r_len + LW'(1);
                end
                if (w_hs) begin
                    r_bad <= w_bad_nxt;
                    r_ovf <= w_ovf_nxt;
                end
            end
            if (r_state == WAIT_DIG) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (w_cap) begin
                r_result_digest <= w_cap_digest;
                r_result_err    <= w_cap_err;
            end
        end
    end

    assign result_digest = r_result_digest;
    assign result_err    = r_result_err;

endmodule

// File: tb/tb_lh_msg_framer.sv
// tb/tb_lh_msg_framer.sv - randomized self-checking bench for lh_msg_framer
module tb_lh_msg_framer;

    localparam int MAX_LEN = 32;
    localparam int TO      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  message_byte;
    logic        message_valid;
    logic [63:0] digest;
    logic        digest_ready;
    logic        err_invalid_message_byte;
    logic [63:0] result_digest;
    logic [1:0]  result_err;
    logic        result_valid;
    logic        result_ready;

    always #5 clk = ~clk;

    lh_msg_framer #(
        .MAX_LEN        (MAX_LEN),
        .DIGEST_TIMEOUT (TO)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_byte                  (in_byte),
        .in_valid                 (in_valid),
        .in_last                  (in_last),
        .in_ready                 (in_ready),
        .message_byte             (message_byte),
        .message_valid            (message_valid),
        .digest                   (digest),
        .digest_ready             (digest_ready),
        .err_invalid_message_byte (err_invalid_message_byte),
        .result_digest            (result_digest),
        .result_err               (result_err),
        .result_valid             (result_valid),
        .result_ready             (result_ready)
    );

    typedef struct packed {
        logic [7:0]  mb;
        logic        mv;
        logic        ir;
        logic        rv;
        logic [63:0] dg;
        logic [1:0]  er;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_tl[$];
    exp_t       cur_e;
    exp_t       idle_e;
    logic [7:0] msg_q[$];
    logic [7:0] bad_tab[6] = '{8'h00, 8'hFF, 8'h7F, 8'h1F, 8'hA0, 8'h80};
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;

    function automatic exp_t mk(input logic [7:0] mb, input logic mv, input logic ir,
                                input logic rv, input logic [63:0] dg, input logic [1:0] er);
        exp_t e;
        e.mb = mb; e.mv = mv; e.ir = ir; e.rv = rv; e.dg = dg; e.er = er;
        return e;
    endfunction

    function automatic bit ok_char(input logic [7:0] b);
        return b inside {[8'h20:8'h7E], [8'hA1:8'hFE]};
    endfunction

    function automatic logic [7:0] rand_valid();
        if ($urandom_range(1) == 0) return 8'($urandom_range(8'h20, 8'h7E));
        return 8'($urandom_range(8'hA1, 8'hFE));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur_e = exp_q.pop_front();
            else                  cur_e = idle_e;
            chk("message_byte",  64'(message_byte),  64'(cur_e.mb));
            chk("message_valid", 64'(message_valid), 64'(cur_e.mv));
            chk("in_ready",      64'(in_ready),      64'(cur_e.ir));
            chk("result_valid",  64'(result_valid),  64'(cur_e.rv));
            if (cur_e.rv) begin
                chk("result_digest", result_digest,    cur_e.dg);
                chk("result_err",    64'(result_err),  64'(cur_e.er));
            end
        end
    end

    // Sends msg_q, predicts the whole framing/result timeline from the protocol rules, then plays the
    // core and consumer side of that timeline. rst_at >= 0 pulses reset in that timeline cycle.
    task automatic send_msg(input int gap, input int d, input int inj, input int rdly,
                            input logic [63:0] dval, input int rst_at);
        int          n;
        bit          bad;
        exp_t        tl[$];
        int          t_res;
        int          t_dig;
        int          t_inj;
        logic [1:0]  er;
        logic [63:0] dg;
        n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_byte  = msg_q[i];
            in_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        bad = 1'b0;
        foreach (msg_q[i]) if (!ok_char(msg_q[i])) bad = 1'b1;
        t_dig = -1;
        t_inj = -1;
        if (bad || n > MAX_LEN) begin
            er    = bad ? 2'd1 : 2'd2;
            dg    = '0;
            t_res = 0;
        end else begin
            tl.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, '0, 2'd0));
            for (int j = 0; j < n; j++) begin
                tl.push_back(mk(msg_q[j], 1'b0, 1'b0, 1'b0, '0, 2'd0));
                if (j == inj) break;
            end
            if (inj >= 0 && inj < n) begin
                er    = 2'd1;
                dg    = '0;
                t_inj = 1 + inj;
            end else if (d < TO) begin
                repeat (d + 1) tl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, '0, 2'd0));
                er    = 2'd0;
                dg    = dval;
                t_dig = n + 1 + d;
            end else begin
                repeat (TO) tl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, '0, 2'd0));
                er = 2'd3;
                dg = '0;
            end
            t_res = tl.size();
        end
        repeat (rdly + 1) tl.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, dg, er));
        last_tl = tl;
        foreach (tl[k]) exp_q.push_back(tl[k]);
        for (int t = 0; t < tl.size(); t++) begin
            digest                   = (t == t_dig) ? dval : {$urandom, $urandom};
            digest_ready             = (t == t_dig);
            err_invalid_message_byte = (t == t_inj);
            result_ready             = (t == t_res + rdly) || (t < t_res && $urandom_range(1) == 1);
            in_valid                 = ($urandom_range(1) == 1);
            in_byte                  = 8'($urandom);
            rst                      = (t == rst_at);
            @(posedge clk); #1;
            digest_ready             = 1'b0;
            err_invalid_message_byte = 1'b0;
            result_ready             = 1'b0;
            in_valid                 = 1'b0;
            if (rst) begin
                rst = 1'b0;
                exp_q.delete();
                break;
            end
        end
        msg_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit1[5] = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
        int zc;
        int n;
        int mode;
        idle_e                   = mk(8'hFF, 1'b0, 1'b1, 1'b0, '0, 2'd0);
        rst                      = 1'b1;
        in_byte                  = 8'h00;
        in_valid                 = 1'b0;
        in_last                  = 1'b0;
        digest                   = '0;
        digest_ready             = 1'b0;
        err_invalid_message_byte = 1'b0;
        result_ready             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_result_digest", result_digest,   64'd0);
        chk("reset_result_err",    64'(result_err), 64'd0);
        @(posedge clk); #1;

        // 1: "abc", digest two cycles after the tail first appears
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(0, 2, -1, 0, 64'h0123456789ABCDEF, -1);
        chk("pin1_len", 64'(last_tl.size()), 64'd8);
        for (int k = 0; k < 5; k++) chk("pin1_byte", 64'(last_tl[k].mb), 64'(lit1[k]));
        chk("pin1_head_valid", 64'(last_tl[0].mv), 64'd1);
        chk("pin1_digest", last_tl[7].dg, 64'h0123456789ABCDEF);
        chk("pin1_err", 64'(last_tl[7].er), 64'd0);

        // 2: bad character in the middle
        msg_q = '{8'h61, 8'h7F, 8'h62};
        send_msg(0, 2, -1, 0, 64'h1111, -1);
        chk("pin2_len", 64'(last_tl.size()), 64'd1);
        chk("pin2_err", 64'(last_tl[0].er), 64'd1);
        chk("pin2_digest", last_tl[0].dg, 64'd0);

        // 3: one byte past the buffer
        repeat (33) msg_q.push_back(8'h41);
        send_msg(0, 2, -1, 1, 64'h2222, -1);
        chk("pin3_err", 64'(last_tl[0].er), 64'd2);

        // 4: core never answers
        msg_q = '{8'h78};
        send_msg(0, TO + 5, -1, 0, 64'h3333, -1);
        zc = 0;
        foreach (last_tl[k]) if (last_tl[k].mb == 8'h00 && !last_tl[k].rv) zc++;
        chk("pin4_tail_cycles", 64'(zc), 64'd16);
        chk("pin4_err", 64'(last_tl[last_tl.size() - 1].er), 64'd3);

        // 5: consumer stalls, then a new message
        msg_q = '{8'h71};
        send_msg(0, 0, -1, 10, 64'hDEADBEEF00C0FFEE, -1);
        msg_q = '{8'h7A};
        send_msg(0, 1, -1, 0, 64'h0A0B0C0D0E0F1011, -1);

        // 6: reset in the middle of the body of a 20-byte message
        repeat (20) msg_q.push_back(rand_valid());
        send_msg(0, 3, -1, 0, 64'h4444, 8);
        @(negedge clk);
        chk("rst6_digest", result_digest,   64'd0);
        chk("rst6_err",    64'(result_err), 64'd0);
        @(posedge clk); #1;
        repeat (12) msg_q.push_back(rand_valid());
        send_msg(10, 4, -1, 0, 64'h5555AAAA5555AAAA, -1);

        // Digest in the timeout cycle wins; full-length message exactly fits
        repeat (MAX_LEN) msg_q.push_back(rand_valid());
        send_msg(0, TO - 1, -1, 0, 64'h6666, -1);
        msg_q = '{8'hA1, 8'hFE, 8'h20, 8'h7E};
        send_msg(0, TO, -1, 0, 64'h7777, -1);
        msg_q = '{8'h41, 8'h42};
        send_msg(0, 0, 1, 0, 64'h8888, -1);

        for (int m = 0; m < 30; m++) begin
            mode = $urandom_range(9);
            n = (mode == 0) ? $urandom_range(MAX_LEN + 1, MAX_LEN + 3) : $urandom_range(1, MAX_LEN);
            repeat (n) msg_q.push_back(rand_valid());
            if (mode == 1) msg_q[$urandom_range(n - 1)] = bad_tab[$urandom_range(5)];
            send_msg($urandom_range(0, 30), $urandom_range(0, TO + 2),
                     (mode == 2) ? $urandom_range(n - 1) : -1,
                     $urandom_range(0, 3), {$urandom, $urandom}, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
